// File: rtl/condlogic.sv
// ARM-style conditional execution unit: gates decoder write requests with the
// condition field evaluated against the architectural NZCV flags.

module condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);
  logic n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b1;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = ~(n ^ v);
      4'b1011: condex = n ^ v;
      4'b1100: condex = ~z & ~(n ^ v);
      4'b1101: condex = z | (n ^ v);
      // 1110 (AL) and 1111 both execute unconditionally
      default: condex = 1'b1;
    endcase
  end
endmodule

module condlogic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       Stall,
  input  logic       Flush,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic       CondExR,
  output logic [3:0] Flags
);
  logic en;

  // Condition is judged on the committed flags, so an instruction never sees
  // its own ALU result.
  condcheck u_condcheck (
    .cond   (Cond),
    .flags  (Flags),
    .condex (CondEx)
  );

  assign en       = CondEx & ~Stall & ~Flush;
  assign PCSrc    = PCS  & en;
  assign MemWrite = MemW & en;
  assign RegWrite = RegW & en & ~NoWrite;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (en & FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
      if (en & FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      CondExR <= 1'b0;
    else if (Flush) CondExR <= 1'b0;
    else if (!Stall) CondExR <= CondEx;
  end
endmodule
